// File: rtl/qix_cpu_clkgen.sv
// 6809E E/Q quadrature clock generator for the Video and Data CPU boards.
// One phase counter drives both CPUs; the Data CPU runs a fixed SKEW behind.
module qix_cpu_clkgen #(
  parameter int          DIV           = 16,
  parameter int          SKEW          = 8,
  parameter int          PW            = 4,
  parameter logic [31:0] BUS_RESET_VAL = 32'h0
) (
  input  logic          clk_20m,
  input  logic          reset_n,
  input  logic          pause,
  output logic          vid_E,
  output logic          vid_Q,
  output logic          vid_E_rise,
  output logic          vid_E_fall,
  output logic          dat_E,
  output logic          dat_Q,
  output logic          dat_E_rise,
  output logic          dat_E_fall,
  output logic [PW-1:0] phase,
  output logic          paused,
  output logic [31:0]   bus_cycles
);

  localparam logic [PW-1:0] LP_LAST   = PW'(DIV - 1);
  localparam logic [PW-1:0] LP_Q_LO   = PW'(DIV / 4);
  localparam logic [PW-1:0] LP_E_LO   = PW'(DIV / 2);
  localparam logic [PW-1:0] LP_Q_HI   = PW'((3 * DIV) / 4);
  localparam logic [PW-1:0] LP_PD_OFS = PW'((DIV - SKEW) % DIV);
  localparam logic [PW:0]   LP_DIV_W  = (PW + 1)'(DIV);

  logic [PW-1:0] r_phase;
  logic          r_vid_E, r_vid_Q, r_vid_E_rise, r_vid_E_fall;
  logic          r_dat_E, r_dat_Q, r_dat_E_rise, r_dat_E_fall;
  logic          r_paused;
  logic [31:0]   r_bus_cycles;

  logic          w_hold;
  logic          w_wrap;
  logic          w_adv;
  logic [PW-1:0] w_phase_nxt;
  logic [PW-1:0] w_pd_nxt;

  function automatic logic f_q(input logic [PW-1:0] p);
    return (p >= LP_Q_LO) && (p < LP_Q_HI);
  endfunction

  function automatic logic f_e(input logic [PW-1:0] p);
    return p >= LP_E_LO;
  endfunction

  // (p + DIV - SKEW) mod DIV; both operands are below DIV so one subtract suffices
  function automatic logic [PW-1:0] f_data_phase(input logic [PW-1:0] p);
    logic [PW:0] s;
    s = {1'b0, p} + {1'b0, LP_PD_OFS};
    if (s >= LP_DIV_W) s = s - LP_DIV_W;
    return s[PW-1:0];
  endfunction

  assign w_hold      = pause && (r_phase == '0);
  assign w_wrap      = (r_phase == LP_LAST);
  assign w_adv       = !w_hold;
  assign w_phase_nxt = w_hold ? r_phase : (w_wrap ? '0 : r_phase + 1'b1);
  assign w_pd_nxt    = f_data_phase(w_phase_nxt);

  // Levels and strobes are decoded from the next phase so every output lines up with r_phase
  always_ff @(posedge clk_20m) begin
    if (!reset_n) begin
      r_phase      <= '0;
      r_vid_E      <= 1'b0;
      r_vid_Q      <= 1'b0;
      r_vid_E_rise <= 1'b0;
      r_vid_E_fall <= 1'b0;
      r_dat_E      <= 1'b0;
      r_dat_Q      <= 1'b0;
      r_dat_E_rise <= 1'b0;
      r_dat_E_fall <= 1'b0;
      r_paused     <= 1'b0;
      r_bus_cycles <= BUS_RESET_VAL;
    end else begin
      r_phase      <= w_phase_nxt;
      r_vid_E      <= f_e(w_phase_nxt);
      r_vid_Q      <= f_q(w_phase_nxt);
      r_vid_E_rise <= w_adv && (w_phase_nxt == LP_E_LO);
      r_vid_E_fall <= w_adv && w_wrap;
      r_dat_E      <= f_e(w_pd_nxt);
      r_dat_Q      <= f_q(w_pd_nxt);
      r_dat_E_rise <= w_adv && (w_pd_nxt == LP_E_LO);
      r_dat_E_fall <= w_adv && (w_pd_nxt == '0);
      r_paused     <= w_hold;
      if (w_adv && w_wrap) r_bus_cycles <= r_bus_cycles + 32'd1;
    end
  end

  assign vid_E      = r_vid_E;
  assign vid_Q      = r_vid_Q;
  assign vid_E_rise = r_vid_E_rise;
  assign vid_E_fall = r_vid_E_fall;
  assign dat_E      = r_dat_E;
  assign dat_Q      = r_dat_Q;
  assign dat_E_rise = r_dat_E_rise;
  assign dat_E_fall = r_dat_E_fall;
  assign phase      = r_phase;
  assign paused     = r_paused;
  assign bus_cycles = r_bus_cycles;

endmodule

// File: tb/tb_qix_cpu_clkgen.sv
// Directed bench for qix_cpu_clkgen: default build, SKEW=0 build and a
// SKEW=4 build with the bus counter starting near its wrap point.
module tb_qix_cpu_clkgen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, pause;

  logic       a_vE, a_vQ, a_vR, a_vF, a_dE, a_dQ, a_dR, a_dF, a_pz;
  logic [3:0] a_ph;
  logic [31:0] a_bus;
  logic       z_vE, z_vQ, z_vR, z_vF, z_dE, z_dQ, z_dR, z_dF, z_pz;
  logic [3:0] z_ph;
  logic [31:0] z_bus;
  logic       f_vE, f_vQ, f_vR, f_vF, f_dE, f_dQ, f_dR, f_dF, f_pz;
  logic [3:0] f_ph;
  logic [31:0] f_bus;

  qix_cpu_clkgen u_dut (
    .clk_20m(clk), .reset_n(reset_n), .pause(pause),
    .vid_E(a_vE), .vid_Q(a_vQ), .vid_E_rise(a_vR), .vid_E_fall(a_vF),
    .dat_E(a_dE), .dat_Q(a_dQ), .dat_E_rise(a_dR), .dat_E_fall(a_dF),
    .phase(a_ph), .paused(a_pz), .bus_cycles(a_bus));

  qix_cpu_clkgen #(.SKEW(0)) u_s0 (
    .clk_20m(clk), .reset_n(reset_n), .pause(pause),
    .vid_E(z_vE), .vid_Q(z_vQ), .vid_E_rise(z_vR), .vid_E_fall(z_vF),
    .dat_E(z_dE), .dat_Q(z_dQ), .dat_E_rise(z_dR), .dat_E_fall(z_dF),
    .phase(z_ph), .paused(z_pz), .bus_cycles(z_bus));

  qix_cpu_clkgen #(.SKEW(4), .BUS_RESET_VAL(32'hFFFF_FFFE)) u_s4 (
    .clk_20m(clk), .reset_n(reset_n), .pause(pause),
    .vid_E(f_vE), .vid_Q(f_vQ), .vid_E_rise(f_vR), .vid_E_fall(f_vF),
    .dat_E(f_dE), .dat_Q(f_dQ), .dat_E_rise(f_dR), .dat_E_fall(f_dF),
    .phase(f_ph), .paused(f_pz), .bus_cycles(f_bus));

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       pz_in;
    logic [3:0] ph;
    logic       vE, vQ, vR, vF, dE, dQ, dR, dF, pz;
    logic [1:0] bd;
  } row_t;

  typedef struct packed {
    logic [5:0] c;
    logic       r, f;
    logic [1:0] bus;
  } ev_t;

  row_t t4[18];
  ev_t  t1[8];

  function automatic row_t mk(input int pin, input int ph, input int ve, input int vq,
                              input int vr, input int vf, input int de, input int dq,
                              input int dr, input int df, input int pz, input int bd);
    row_t r;
    r.pz_in = pin[0]; r.ph = ph[3:0];
    r.vE = ve[0]; r.vQ = vq[0]; r.vR = vr[0]; r.vF = vf[0];
    r.dE = de[0]; r.dQ = dq[0]; r.dR = dr[0]; r.dF = df[0];
    r.pz = pz[0]; r.bd = bd[1:0];
    return r;
  endfunction

  function automatic ev_t mkev(input int c, input int r, input int f, input int bus);
    ev_t e;
    e.c = c[5:0]; e.r = r[0]; e.f = f[0]; e.bus = bus[1:0];
    return e;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs of one instance for Video phase ph; adv says whether the last edge advanced.
  task automatic chk_inst(input string tag, input int skew, input int ph, input bit adv,
                          input logic [31:0] bus, input bit pz,
                          input logic [3:0] aph, input logic vE, input logic vQ,
                          input logic vR, input logic vF, input logic dE, input logic dQ,
                          input logic dR, input logic dF, input logic apz,
                          input logic [31:0] abus);
    int pd;
    pd = (ph + 16 - skew) % 16;
    chk32($sformatf("%s phase", tag), 32'(aph), ph);
    chk1($sformatf("%s vid_E", tag), vE, ph >= 8);
    chk1($sformatf("%s vid_Q", tag), vQ, (ph >= 4) && (ph < 12));
    chk1($sformatf("%s vid_E_rise", tag), vR, adv && (ph == 8));
    chk1($sformatf("%s vid_E_fall", tag), vF, adv && (ph == 0));
    chk1($sformatf("%s dat_E", tag), dE, pd >= 8);
    chk1($sformatf("%s dat_Q", tag), dQ, (pd >= 4) && (pd < 12));
    chk1($sformatf("%s dat_E_rise", tag), dR, adv && (pd == 8));
    chk1($sformatf("%s dat_E_fall", tag), dF, adv && (pd == 0));
    chk1($sformatf("%s paused", tag), apz, pz);
    chk32($sformatf("%s bus_cycles", tag), abus, bus);
  endtask

  task automatic chk_main(input string tag, input int ph, input bit adv,
                          input logic [31:0] bus, input bit pz);
    chk_inst(tag, 8, ph, adv, bus, pz, a_ph, a_vE, a_vQ, a_vR, a_vF,
             a_dE, a_dQ, a_dR, a_dF, a_pz, a_bus);
  endtask

  task automatic chk_rst(input string tag, input logic [3:0] aph, input logic vE,
                         input logic vQ, input logic vR, input logic vF, input logic dE,
                         input logic dQ, input logic dR, input logic dF, input logic apz,
                         input logic [31:0] abus, input logic [31:0] bus);
    chk32($sformatf("%s phase", tag), 32'(aph), 32'h0);
    chk32($sformatf("%s levels/strobes", tag),
          32'({vE, vQ, vR, vF, dE, dQ, dR, dF, apz}), 32'h0);
    chk32($sformatf("%s bus_cycles", tag), abus, bus);
  endtask

  task automatic chk_reset_all(input string tag);
    chk_rst({tag, " dut"}, a_ph, a_vE, a_vQ, a_vR, a_vF, a_dE, a_dQ, a_dR, a_dF, a_pz, a_bus, 32'h0);
    chk_rst({tag, " s0"}, z_ph, z_vE, z_vQ, z_vR, z_vF, z_dE, z_dQ, z_dR, z_dF, z_pz, z_bus, 32'h0);
    chk_rst({tag, " s4"}, f_ph, f_vE, f_vQ, f_vR, f_vF, f_dE, f_dQ, f_dR, f_dF, f_pz, f_bus,
            32'hFFFF_FFFE);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [31:0] e4;
    // pause_in, phase, vE vQ vR vF, dE dQ dR dF, paused, bus delta
    t4[0]  = mk(0, 0,  0,0,0,1, 1,1,1,0, 0, 1);
    t4[1]  = mk(1, 0,  0,0,0,0, 1,1,0,0, 1, 1);
    t4[2]  = mk(0, 1,  0,0,0,0, 1,1,0,0, 0, 1);
    t4[3]  = mk(0, 2,  0,0,0,0, 1,1,0,0, 0, 1);
    t4[4]  = mk(0, 3,  0,0,0,0, 1,1,0,0, 0, 1);
    t4[5]  = mk(0, 4,  0,1,0,0, 1,0,0,0, 0, 1);
    t4[6]  = mk(0, 5,  0,1,0,0, 1,0,0,0, 0, 1);
    t4[7]  = mk(0, 6,  0,1,0,0, 1,0,0,0, 0, 1);
    t4[8]  = mk(0, 7,  0,1,0,0, 1,0,0,0, 0, 1);
    t4[9]  = mk(0, 8,  1,1,1,0, 0,0,0,1, 0, 1);
    t4[10] = mk(0, 9,  1,1,0,0, 0,0,0,0, 0, 1);
    t4[11] = mk(0, 10, 1,1,0,0, 0,0,0,0, 0, 1);
    t4[12] = mk(0, 11, 1,1,0,0, 0,0,0,0, 0, 1);
    t4[13] = mk(0, 12, 1,0,0,0, 0,1,0,0, 0, 1);
    t4[14] = mk(0, 13, 1,0,0,0, 0,1,0,0, 0, 1);
    t4[15] = mk(0, 14, 1,0,0,0, 0,1,0,0, 0, 1);
    t4[16] = mk(0, 15, 1,0,0,0, 0,1,0,0, 0, 1);
    t4[17] = mk(0, 0,  0,0,0,1, 1,1,1,0, 0, 2);
    // cycle after release, vid_E_rise, vid_E_fall, bus_cycles
    t1[0] = mkev(8, 1, 0, 0);  t1[1] = mkev(16, 0, 1, 1);
    t1[2] = mkev(24, 1, 0, 1); t1[3] = mkev(32, 0, 1, 2);
    t1[4] = mkev(40, 1, 0, 2); t1[5] = mkev(48, 0, 1, 3);
    t1[6] = mkev(56, 1, 0, 3); t1[7] = mkev(63, 0, 0, 3);

    reset_n = 1'b0;
    pause   = 1'b0;
    repeat (3) tick();
    chk_reset_all("reset");

    // Free run from reset release, all three builds side by side
    reset_n = 1'b1;
    for (int c = 1; c < 64; c++) begin
      tick();
      chk_main($sformatf("run c%0d", c), c % 16, 1'b1, 32'(c / 16), 1'b0);
      chk_inst($sformatf("skew0 c%0d", c), 0, c % 16, 1'b1, 32'(c / 16), 1'b0,
               z_ph, z_vE, z_vQ, z_vR, z_vF, z_dE, z_dQ, z_dR, z_dF, z_pz, z_bus);
      e4 = 32'hFFFF_FFFE + 32'(c / 16);
      chk_inst($sformatf("skew4 c%0d", c), 4, c % 16, 1'b1, e4, 1'b0,
               f_ph, f_vE, f_vQ, f_vR, f_vF, f_dE, f_dQ, f_dR, f_dF, f_pz, f_bus);
      for (int j = 0; j < 8; j++) begin
        if (t1[j].c == c[5:0]) begin
          chk1($sformatf("event c%0d rise", c), a_vR, t1[j].r);
          chk1($sformatf("event c%0d fall", c), a_vF, t1[j].f);
          chk32($sformatf("event c%0d bus", c), a_bus, 32'(t1[j].bus));
        end
      end
    end

    // Pause raised mid bus cycle at phase 5 and held for 40 cycles
    n = 0;
    while (a_ph != 4'd5 && n < 32) begin tick(); n++; end
    chk32("pause-mid reach phase 5", 32'(a_ph), 32'd5);
    pause = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k <= 10)      chk_main($sformatf("pause-mid k%0d", k), 5 + k, 1'b1, 32'd4, 1'b0);
      else if (k == 11) chk_main($sformatf("pause-mid k%0d", k), 0, 1'b1, 32'd5, 1'b0);
      else              chk_main($sformatf("pause-mid k%0d", k), 0, 1'b0, 32'd5, 1'b1);
    end
    pause = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk_main($sformatf("resume k%0d", k), k, 1'b1, 32'd5, 1'b0);
    end

    // One-cycle pause exactly at phase 0 stretches the bus cycle to 17
    n = 0;
    while (a_ph != 4'd15 && n < 32) begin tick(); n++; end
    chk32("pause-1 reach phase 15", 32'(a_ph), 32'd15);
    n = 0;
    for (int r = 0; r < 18; r++) begin
      pause = t4[r].pz_in;
      tick();
      chk32($sformatf("pause-1 r%0d phase", r), 32'(a_ph), 32'(t4[r].ph));
      chk32($sformatf("pause-1 r%0d outputs", r),
            32'({a_vE, a_vQ, a_vR, a_vF, a_dE, a_dQ, a_dR, a_dF, a_pz}),
            32'({t4[r].vE, t4[r].vQ, t4[r].vR, t4[r].vF,
                 t4[r].dE, t4[r].dQ, t4[r].dR, t4[r].dF, t4[r].pz}));
      chk32($sformatf("pause-1 r%0d bus", r), a_bus, 32'd5 + 32'(t4[r].bd));
      if (a_pz) n++;
    end
    chk32("pause-1 paused cycles", 32'(n), 32'd1);

    // Reset at phase 11 while running
    n = 0;
    while (a_ph != 4'd11 && n < 32) begin tick(); n++; end
    chk32("rst-run reach phase 11", 32'(a_ph), 32'd11);
    reset_n = 1'b0;
    tick();
    chk_reset_all("rst-run");
    reset_n = 1'b1;
    tick();
    chk_main("rst-run after1", 1, 1'b1, 32'd0, 1'b0);
    tick();
    chk_main("rst-run after2", 2, 1'b1, 32'd0, 1'b0);

    // Reset in the middle of a pause, then release with pause still high
    pause = 1'b1;
    n = 0;
    while (!a_pz && n < 40) begin tick(); n++; end
    chk1("rst-pause reached paused", a_pz, 1'b1);
    repeat (2) tick();
    reset_n = 1'b0;
    tick();
    chk_reset_all("rst-pause");
    reset_n = 1'b1;
    tick();
    chk_main("rst-pause release held", 0, 1'b0, 32'd0, 1'b1);
    pause = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk_main($sformatf("rst-pause resume k%0d", k), k % 16, 1'b1, 32'(k / 16), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qix_cpu_clkgen.md
Name:
qix_cpu_clkgen

Overview:
- Generates the 6809E E/Q quadrature clocks (as level signals plus one-cycle edge strobes) for the Video CPU board and the Data CPU board.
- Derived from clk_20m by a single phase counter, so both CPUs stay phase-locked with a fixed, parameterised skew.
- Sits directly upstream of the Video CPU board (its E and Q inputs) and the Data CPU board.
- Also implements the pause stall and a free-running bus-cycle counter for profiling.

Parameters:
- DIV, 16: clk_20m cycles per CPU bus cycle. Must be a multiple of 4, ≥ 8. Default gives 1.25 MHz.
- SKEW, 8: phase lag of the Data CPU clocks behind the Video CPU clocks, in clk_20m cycles. Range 0..DIV-1.
- PW, 4: phase counter width. Must satisfy 2^PW ≥ DIV.

Ports:
- clk_20m, in, 1: system clock, 20 MHz.
- reset_n, in, 1: synchronous, active-low reset.
- pause, in, 1: request to stall both CPUs at the next bus-cycle boundary.
- vid_E, out, 1: Video CPU E clock level.
- vid_Q, out, 1: Video CPU Q clock level (leads E by 90°).
- vid_E_rise, out, 1: one-cycle pulse in the cycle vid_E goes 0→1.
- vid_E_fall, out, 1: one-cycle pulse in the cycle vid_E goes 1→0 (write strobe timing).
- dat_E, out, 1: Data CPU E clock level.
- dat_Q, out, 1: Data CPU Q clock level.
- dat_E_rise, out, 1: one-cycle pulse on dat_E rising.
- dat_E_fall, out, 1: one-cycle pulse on dat_E falling.
- phase, out, PW: current Video CPU phase, 0..DIV-1.
- paused, out, 1: 1 while the counter is held by pause.
- bus_cycles, out, 32: count of completed Video CPU bus cycles (vid_E_fall events); wraps.

Behaviour:
- Reset (reset_n=0 sampled on a clk_20m edge):
  - phase=0, bus_cycles=0, paused=0.
  - All E/Q levels 0, all strobes 0.
  - Takes priority over every other condition, including reset asserted mid-cycle or mid-pause.
- Phase counter:
  - Each cycle, phase advances p→p+1; at DIV-1 it wraps to 0.
  - It holds instead when hold=1, where hold = pause & (phase==0).
  - First cycle after reset release: phase goes to 1, unless pause=1.
- Level decode (all outputs registered, glitch-free):
  - For the currently registered phase p:
    - vid_Q = (DIV/4 ≤ p < 3·DIV/4)
    - vid_E = (p ≥ DIV/2)
  - Data phase pd = (p + DIV − SKEW) mod DIV. dat_Q and dat_E use the same decode on pd.
  - With defaults the duty cycle is 50% for both E and Q, and Q leads E by DIV/4 = 4 cycles.
  - At phase 0 the Video CPU has E=0, Q=0. With SKEW=DIV/2 the data clocks are exactly inverted relative to video.
- Strobes:
  - vid_E_rise=1 exactly in the cycle where phase becomes DIV/2.
  - vid_E_fall=1 exactly in the cycle where phase becomes 0 via wrap from DIV-1.
  - dat_E_rise and dat_E_fall are the equivalent events on pd.
  - Strobes never assert while holding. Re-entering a held phase generates no strobe.
  - Each strobe is high for exactly one clk_20m cycle.
- Pause:
  - Honoured only at phase 0, i.e. Video CPU between bus cycles with E=Q=0.
  - If pause rises mid-cycle, the current bus cycle completes normally, then holds at 0.
  - paused=1 on every cycle phase is held at 0 with pause=1. It deasserts in the same cycle the counter resumes (pause=0 sampled → phase=1 next cycle).
  - Data clock levels are frozen at their pd=DIV−SKEW (mod DIV) values while paused.
  - A pause pulse of one cycle at phase 0 stretches the bus cycle by exactly one clk_20m cycle.
- bus_cycles:
  - Increments by 1 with each vid_E_fall.
  - Wraps from 0xFFFFFFFF to 0, with no flag.
- There is no other state and no handshakes. Output timing is fully deterministic from reset release.

Test Plan:
1. Defaults, reset released at t0, pause=0, observe 64 cycles:
   - vid_E_rise at cycles 8/24/40/56 after release.
   - vid_E_fall at 16/32/48.
   - vid_Q high for phases 4..11.
   - dat_E equals ~vid_E every cycle.
   - bus_cycles=3 at cycle 63.
2. SKEW=0 build:
   - dat_E/dat_Q/strobes identical to vid_* every cycle.
   - SKEW=4: dat_E_rise occurs exactly 4 cycles after each vid_E_rise.
3. Assert pause at phase 5 for 40 cycles:
   - Cycle completes, phase holds at 0.
   - paused=1, no strobes, bus_cycles frozen.
   - After pause drops, phase=1 next cycle and vid_E_rise 7 cycles later.
4. Pause held 1 cycle exactly at phase 0:
   - Bus cycle length 17 instead of 16.
   - paused high for exactly 1 cycle.
5. Force bus_cycles to 0xFFFFFFFE via preload, run 2 bus cycles:
   - Reads 0xFFFFFFFF, then 0x00000000.
6. Assert reset_n=0 at phase 11 while paused=0, and again mid-pause:
   - Next edge: phase=0, all levels/strobes 0, bus_cycles=0, paused=0.
   - Resumes cleanly after release.
